// File: rtl/tinyalu_cmd_driver.sv
// rtl/tinyalu_cmd_driver.sv - ALU start/done initiator with command FIFO and response stream
// Commands are buffered, issued one at a time with a done timeout, and answered in order.
module tinyalu_cmd_driver #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_d;
  logic [18:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [TW-1:0]   cnt, cnt_d;
  logic            push, pop;
  logic            start_d, rv_d, rt_d;
  logic [2:0]      op_d;
  logic [7:0]      a_d, b_d;
  logic [15:0]     rr_d;

  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign count_next = count + CW'(push) - CW'(pop);
  assign busy       = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // cmd_ready comes from next occupancy, so a pop only frees a slot one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      cmd_ready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      alu_start   <= start_d;
      alu_op      <= op_d;
      alu_a       <= a_d;
      alu_b       <= b_d;
      rsp_valid   <= rv_d;
      rsp_result  <= rr_d;
      rsp_timeout <= rt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    start_d = alu_start;
    op_d    = alu_op;
    a_d     = alu_a;
    b_d     = alu_b;
    rv_d    = rsp_valid;
    rr_d    = rsp_result;
    rt_d    = rsp_timeout;
    case (state)
      IDLE: begin
        if (pop) begin
          {op_d, a_d, b_d} = mem[rd_ptr];
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // no_op gets a single start cycle and never waits for done
        if (alu_op == 3'b000) begin
          start_d = 1'b0;
          rr_d    = '0;
          rt_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else if (alu_done) begin
          start_d = 1'b0;
          rr_d    = alu_result;
          rt_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          start_d = 1'b0;
          rr_d    = '0;
          rt_d    = 1'b1;
          rv_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      RESP: begin
        start_d = 1'b0;
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// tb/tb_tinyalu_cmd_driver.sv - scoreboard bench for tinyalu_cmd_driver
// Directed commands push expected responses; a negedge monitor pops and compares.
module tb_tinyalu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_timeout;
  logic        busy;

  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  int          alu_lat = 1;
  bit          never_done = 1'b0;
  int          mcyc = 0;

  int total = 0;
  int bad   = 0;
  logic [16:0] sb [$];

  int hi_cnt = 0, last_hi = 0, pulses = 0;

  always #5 clk = ~clk;

  assign alu_done = model_done | stray_done;

  tinyalu_cmd_driver #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return 16'h0000;
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      default: return {8'h00, a} * {8'h00, b};
    endcase
  endfunction

  // ALU model: done pulses alu_lat cycles after start is first sampled
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (alu_start && !model_done && !never_done) begin
      if (mcyc >= alu_lat - 1) begin
        model_done <= 1'b1;
        alu_result <= alu_calc(alu_op, alu_a, alu_b);
        mcyc       <= 0;
      end else begin
        mcyc <= mcyc + 1;
      end
    end else begin
      mcyc <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        pv = 1'b0, pr = 1'b0, pt = 1'b0, ps = 1'b0;
  logic [15:0] pres = '0;
  logic [2:0]  pop_q = '0;
  logic [7:0]  pa = '0, pb = '0;
  logic [16:0] exp_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      ps = 1'b0;
    end else begin
      if (pv && !pr)
        check("rsp_hold", {14'd0, rsp_valid, rsp_timeout, rsp_result}, {14'd0, 1'b1, pt, pres});
      if (ps && alu_start)
        check("alu_stable", {13'd0, alu_op, alu_a, alu_b}, {13'd0, pop_q, pa, pb});
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", {15'd0, rsp_timeout, rsp_result}, 32'h0);
          check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
          exp_rsp = sb.pop_front();
          check("rsp", {15'd0, rsp_timeout, rsp_result}, {15'd0, exp_rsp});
        end
      end
      pv = rsp_valid; pr = rsp_ready; pt = rsp_timeout; pres = rsp_result;
      ps = alu_start; pop_q = alu_op; pa = alu_a; pb = alu_b;
    end
    if (alu_start) begin
      if (hi_cnt == 0) pulses++;
      hi_cnt++;
    end else if (hi_cnt != 0) begin
      last_hi = hi_cnt;
      hi_cnt  = 0;
    end
  end

  // caller is at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic to, input logic [15:0] exp);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("cmd_accept_timeout", 32'd0, 32'd1);
    else sb.push_back({to, exp});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
    @(negedge clk);
  endtask

  task automatic drain;
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(n < 500), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_alu_opab", {13'd0, alu_op, alu_a, alu_b}, 32'd0);
    check("rst_rsp", {14'd0, rsp_valid, rsp_timeout, rsp_result}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // add with single-cycle ALU
    alu_lat = 1;
    send(3'b001, 8'hFF, 8'h01, 1'b0, 16'h0100);
    drain();
    check("add_start_len", 32'(last_hi), 32'd2);

    // back-to-back multiplies, 3-cycle ALU
    alu_lat = 3;
    p0 = pulses;
    send(3'b100, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    send(3'b100, 8'h02, 8'h03, 1'b0, 16'h0006);
    drain();
    check("mul_pulses", 32'(pulses - p0), 32'd2);

    // fill and backpressure
    alu_lat = 1;
    set_ready(1'b0);
    send(3'b011, 8'hA5, 8'h0F, 1'b0, 16'h00AA);
    send(3'b010, 8'hF0, 8'h3C, 1'b0, 16'h0030);
    send(3'b011, 8'h12, 8'h34, 1'b0, 16'h0026);
    send(3'b010, 8'hFF, 8'h0F, 1'b0, 16'h000F);
    send(3'b011, 8'h00, 8'hFF, 1'b0, 16'h00FF);
    repeat (4) @(negedge clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    check("full_busy", 32'(busy), 32'd1);
    check("full_pending", 32'(sb.size()), 32'd5);
    set_ready(1'b1);
    send(3'b010, 8'h5A, 8'h0F, 1'b0, 16'h000A);
    drain();

    // timeout, then a normal command
    never_done = 1'b1;
    send(3'b001, 8'h11, 8'h22, 1'b1, 16'h0000);
    drain();
    check("timeout_start_len", 32'(last_hi), 32'd16);
    never_done = 1'b0;
    send(3'b001, 8'h10, 8'h20, 1'b0, 16'h0030);
    drain();

    // no_op, then a stray done in IDLE
    alu_lat = 2;
    send(3'b000, 8'h12, 8'h34, 1'b0, 16'h0000);
    drain();
    check("noop_start_len", 32'(last_hi), 32'd1);
    repeat (2) @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);

    // reset in the middle of a multiply
    alu_lat = 8;
    send(3'b100, 8'h07, 8'h09, 1'b0, 16'h003F);
    n = 0;
    while (!alu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_start_seen", 32'(alu_start), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_alu_start", 32'(alu_start), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    alu_lat = 1;
    send(3'b011, 8'hA5, 8'h0F, 1'b0, 16'h00AA);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
